// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM states,
// buffer entry layout and the RISC-V field positions used by the decoder port.
package fetch_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          BUF_DEPTH_FIXED  = 2;

    localparam int OPC_HI = 6;
    localparam int OPC_LO = 0;
    localparam int F3_HI  = 14;
    localparam int F3_LO  = 12;
    localparam int F7_HI  = 31;
    localparam int F7_LO  = 25;

    typedef logic [XLEN-1:0] instr_word_t;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        instr_word_t     instr;
    } fetch_entry_t;

    // Redirect targets are forced onto a word boundary by dropping the low two bits.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, instr} between the memory response and the decoder.
// Flush wins over push and pop; a pop frees its slot for a same-cycle push.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem_q [0:1];
    fetch_entry_t mem_d [0:1];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q,  count_d;
    logic         do_pop;
    logic         do_push;

    always_comb begin
        do_pop   = pop && (count_q != 2'd0);
        do_push  = push && ((count_q != 2'd2) || do_pop);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + 2'(do_push) - 2'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues single-cycle-latency memory reads and
// hands fetched words to the decoder through a 2-entry buffer; redirects flush it.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = BUF_DEPTH_FIXED
) (
    input  logic         iClk,
    input  logic         iRst,
    output logic         oImemReq,
    output logic [31:0]  oImemAddr,
    input  logic [31:0]  iImemData,
    input  logic         iRedirect,
    input  logic [31:0]  iRedirectPc,
    output logic         oValid,
    input  logic         iReady,
    output logic [31:0]  oInstr,
    output logic [6:0]   oOpCode,
    output logic [2:0]   oFunct3,
    output logic [6:0]   oFunct7,
    output logic [31:0]  oPc,
    output logic         oMisalign,
    output fetch_state_t oDbgState
);

    // Decoder handshake: an entry transfers in any cycle where oValid & iReady are
    // both high; while oValid is high and iReady low the head fields do not change.

    fetch_state_t state_q,       state_d;
    logic [31:0]  pc_q,          pc_d;
    logic         inflight_q,    inflight_d;
    logic [31:0]  inflight_pc_q, inflight_pc_d;
    logic         kill_q,        kill_d;
    logic         misalign_q,    misalign_d;

    fetch_entry_t head;
    fetch_entry_t push_entry;
    logic [1:0]   count;
    logic [2:0]   credit_use;
    logic         pop;
    logic         push;
    logic         req;

    always_comb begin
        pop        = (count != 2'd0) && iReady;
        credit_use = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
        req        = (state_q == ST_RUN) && (credit_use < 3'(BUF_DEPTH));
        // A killed response belongs to the pre-redirect stream and is dropped.
        push       = inflight_q && !kill_q && !iRedirect;
        push_entry = '{pc: inflight_pc_q, instr: iImemData};
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = req;
        inflight_pc_d = req ? pc_q : inflight_pc_q;
        kill_d        = iRedirect;
        misalign_d    = iRedirect && (iRedirectPc[1:0] != 2'b00);
        case (state_q)
            ST_BOOT:  state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_BOOT;
        endcase
        if (req) begin
            pc_d = pc_q + 32'd4;
        end
        if (iRedirect) begin
            state_d = ST_FLUSH;
            pc_d    = align_word(iRedirectPc);
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            kill_q        <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            kill_q        <= kill_d;
            misalign_q    <= misalign_d;
        end
    end

    fetch_buffer u_buf (
        .clk        (iClk),
        .rst        (iRst),
        .push       (push),
        .pop        (pop),
        .flush      (iRedirect),
        .push_entry (push_entry),
        .head       (head),
        .count      (count)
    );

    // Head fields are zeroed while empty so stale entries never leak to the decoder.
    always_comb begin
        oValid    = (count != 2'd0);
        oInstr    = oValid ? head.instr : '0;
        oPc       = oValid ? head.pc : '0;
        oOpCode   = oInstr[OPC_HI:OPC_LO];
        oFunct3   = oInstr[F3_HI:F3_LO];
        oFunct7   = oInstr[F7_HI:F7_LO];
        oImemReq  = req;
        oImemAddr = pc_q;
        oMisalign = misalign_q;
        oDbgState = state_q;
    end

endmodule
